// File: rtl/mul_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_issue_arbiter
// Purpose  : Shares one multi-cycle multiplier between two requesters
//            (0: integer EX stage, 1: MAC/CSR micro-sequencer). Requests are
//            granted round-robin. Each op is sequenced as a one-cycle start
//            pulse, a busy wait, a result capture and a held response with
//            valid/ready backpressure. The multiplier never sees overlapping
//            starts.
// Ports    : clk, reset_n                   clock, async active-low reset
//            req_valid/req_ready [1:0]      per-requester handshake
//            req_funct3/req_a/req_b/req_tag packed per requester, slot i at [W*i+:W]
//            flush                          kill the in-flight op, no response
//            mul_start/mul_funct3/mul_a/mul_b  multiplier command
//            mul_busy/mul_result            multiplier status and product
//            rsp_valid/rsp_ready            response handshake
//            rsp_id/rsp_tag/rsp_result      response payload
// Revision : 1.0  initial release
// ============================================================================
module mul_issue_arbiter #(
  parameter int XLEN         = 32,
  parameter int TAG_W        = 5,
  parameter int RESULT_DELAY = 1    // 1..3 cycles from busy-low to result-valid
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [5:0]          req_funct3,
  input  logic [2*XLEN-1:0]   req_a,
  input  logic [2*XLEN-1:0]   req_b,
  input  logic [2*TAG_W-1:0]  req_tag,
  input  logic                flush,
  output logic                mul_start,
  output logic [2:0]          mul_funct3,
  output logic [XLEN-1:0]     mul_a,
  output logic [XLEN-1:0]     mul_b,
  input  logic                mul_busy,
  input  logic [XLEN-1:0]     mul_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [XLEN-1:0]     rsp_result
);

  // Number of DRAIN/KDRAIN cycles minus one; the last one captures.
  localparam logic [1:0] c_DRAIN_INIT = 2'(RESULT_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESP   = 3'd4,
    S_KILL   = 3'd5,   // flushed: wait for the multiplier to go idle
    S_KDRAIN = 3'd6    // flushed: let the stale result pass, then discard
  } state_t;

  state_t              r_state;
  logic                r_rr_last;
  logic [1:0]          r_cnt;
  logic                r_mul_start;
  logic [2:0]          r_mul_funct3;
  logic [XLEN-1:0]     r_mul_a;
  logic [XLEN-1:0]     r_mul_b;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [TAG_W-1:0]    r_rsp_tag;
  logic [XLEN-1:0]     r_rsp_result;

  logic                w_grant_id;
  logic [1:0]          w_req_ready;
  logic                w_accept;
  logic [2:0]          w_sel_funct3;
  logic [XLEN-1:0]     w_sel_a;
  logic [XLEN-1:0]     w_sel_b;
  logic [TAG_W-1:0]    w_sel_tag;

  // Grant: a sole requester wins outright; on contention the one that did not
  // win last time goes first. Ready is gated by reset_n so every output reads
  // zero while reset is held.
  always_comb begin
    w_grant_id  = 1'b0;
    w_req_ready = 2'b00;
    if (req_valid == 2'b11) begin
      w_grant_id = ~r_rr_last;
    end else begin
      w_grant_id = req_valid[1];
    end
    if ((r_state == S_IDLE) && !flush && reset_n && (req_valid != 2'b00)) begin
      w_req_ready[w_grant_id] = 1'b1;
    end
  end

  assign w_accept     = |(req_valid & w_req_ready);
  assign w_sel_funct3 = w_grant_id ? req_funct3[5:3]           : req_funct3[2:0];
  assign w_sel_a      = w_grant_id ? req_a[2*XLEN-1:XLEN]      : req_a[XLEN-1:0];
  assign w_sel_b      = w_grant_id ? req_b[2*XLEN-1:XLEN]      : req_b[XLEN-1:0];
  assign w_sel_tag    = w_grant_id ? req_tag[2*TAG_W-1:TAG_W]  : req_tag[TAG_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rr_last    <= 1'b1;
      r_cnt        <= 2'd0;
      r_mul_start  <= 1'b0;
      r_mul_funct3 <= 3'd0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_tag    <= '0;
      r_rsp_result <= '0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rr_last <= w_grant_id;
            r_rsp_id  <= w_grant_id;
            r_rsp_tag <= w_sel_tag;
            if (w_sel_funct3[2]) begin
              // Not a multiply: answer zero without touching the multiplier.
              r_rsp_result <= '0;
              r_rsp_valid  <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_mul_funct3 <= w_sel_funct3;
              r_mul_a      <= w_sel_a;
              r_mul_b      <= w_sel_b;
              r_mul_start  <= 1'b1;
              r_state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_state <= flush ? S_KILL : S_WAIT;
        end
        S_WAIT: begin
          if (flush) begin
            r_state <= S_KILL;
          end else if (!mul_busy) begin
            r_cnt   <= c_DRAIN_INIT;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (flush) begin
            r_state <= S_KILL;
          end else if (r_cnt == 2'd0) begin
            r_rsp_result <= mul_result;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_RESP: begin
          // Flush beats a same-cycle rsp_ready: the response is withdrawn.
          if (flush || rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_KILL: begin
          if (!mul_busy) begin
            r_cnt   <= c_DRAIN_INIT;
            r_state <= S_KDRAIN;
          end
        end
        S_KDRAIN: begin
          if (r_cnt == 2'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = w_req_ready;
  assign mul_start  = r_mul_start;
  assign mul_funct3 = r_mul_funct3;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_result = r_rsp_result;

  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset_n) !(mul_start && mul_busy)
  );

endmodule
`default_nettype wire
